// File: rtl/cdma_pkg.sv
// cdma_pkg: shared widths, defaults and state encodings for the despread correlator.
package cdma_pkg;

    localparam int GOLD_LEN = 31;

    function automatic int chip_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    typedef enum logic {IDLE, ACCUM} dp_state_t;
    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

endpackage

// File: rtl/cdma_lock_detect.sv
// cdma_lock_detect: lock FSM driven by per-symbol strong/weak verdicts.
module cdma_lock_detect import cdma_pkg::*; #(
    parameter int LOCK_CNT = 4,
    parameter int MISS_CNT = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sym_valid,
    input  logic sym_strong,
    input  logic clear,
    output logic lock_o
);

    localparam int SW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(MISS_CNT + 1);

    lock_state_t state, state_n;
    logic [SW-1:0] strong_cnt, strong_cnt_n;
    logic [MW-1:0] miss_cnt, miss_cnt_n;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= UNLOCKED;
            strong_cnt <= '0;
            miss_cnt   <= '0;
        end else begin
            state      <= state_n;
            strong_cnt <= strong_cnt_n;
            miss_cnt   <= miss_cnt_n;
        end
    end

    // Counters clear on every state change, so they never exceed their thresholds.
    always_comb begin
        state_n      = state;
        strong_cnt_n = strong_cnt;
        miss_cnt_n   = miss_cnt;
        if (clear) begin
            state_n      = UNLOCKED;
            strong_cnt_n = '0;
            miss_cnt_n   = '0;
        end else if (sym_valid) begin
            if (state == UNLOCKED) begin
                if (!sym_strong) begin
                    strong_cnt_n = '0;
                end else if (strong_cnt == SW'(LOCK_CNT - 1)) begin
                    state_n      = LOCKED;
                    strong_cnt_n = '0;
                    miss_cnt_n   = '0;
                end else begin
                    strong_cnt_n = strong_cnt + SW'(1);
                end
            end else begin
                if (sym_strong) begin
                    miss_cnt_n = '0;
                end else if (miss_cnt == MW'(MISS_CNT - 1)) begin
                    state_n      = UNLOCKED;
                    strong_cnt_n = '0;
                    miss_cnt_n   = '0;
                end else begin
                    miss_cnt_n = miss_cnt + MW'(1);
                end
            end
        end
    end

    assign lock_o = (state == LOCKED);

endmodule

// File: rtl/cdma_despread_correlator.sv
// cdma_despread_correlator: integrates despread chips over one Gold period,
// makes a majority bit decision, grades confidence and tracks lock.
module cdma_despread_correlator import cdma_pkg::*; #(
    parameter int CHIPS_PER_BIT = GOLD_LEN,
    parameter int STRONG_THR    = 26,
    parameter int LOCK_CNT      = 4,
    parameter int MISS_CNT      = 2,
    localparam int AW           = chip_cnt_w(CHIPS_PER_BIT)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          sync_i,
    input  logic          chip_en_i,
    input  logic          chip_i,
    output logic          bit_o,
    output logic          bit_valid_o,
    output logic [AW-1:0] metric_o,
    output logic          strong_o,
    output logic          lock_o
);

    localparam int IW = $clog2(CHIPS_PER_BIT);

    dp_state_t state, state_n;
    logic [AW-1:0] acc, acc_n, sum;
    logic [IW-1:0] idx, idx_n;
    logic sym_end, sym_strong;

    assign sum        = acc + AW'(chip_i);
    assign sym_end    = en_i && state == ACCUM && chip_en_i && idx == IW'(CHIPS_PER_BIT - 1);
    assign sym_strong = sum >= AW'(STRONG_THR) || sum <= AW'(CHIPS_PER_BIT - STRONG_THR);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            acc   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            idx   <= idx_n;
        end
    end

    // A symbol-end chip always completes, even when sync arrives with it.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        idx_n   = idx;
        if (!en_i) begin
            state_n = IDLE;
            acc_n   = '0;
            idx_n   = '0;
        end else if (state == IDLE) begin
            state_n = sync_i ? ACCUM : IDLE;
        end else if (sym_end) begin
            acc_n = '0;
            idx_n = '0;
        end else if (sync_i) begin
            acc_n = chip_en_i ? AW'(chip_i) : '0;
            idx_n = chip_en_i ? IW'(1) : '0;
        end else if (chip_en_i) begin
            acc_n = sum;
            idx_n = idx + IW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_o       <= 1'b0;
            bit_valid_o <= 1'b0;
            metric_o    <= '0;
            strong_o    <= 1'b0;
        end else begin
            bit_valid_o <= sym_end;
            if (sym_end) begin
                metric_o <= sum;
                bit_o    <= sum > AW'(CHIPS_PER_BIT / 2);
                strong_o <= sym_strong;
            end
        end
    end

    cdma_lock_detect #(
        .LOCK_CNT(LOCK_CNT),
        .MISS_CNT(MISS_CNT)
    ) u_lock (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .sym_valid (sym_end),
        .sym_strong(sym_strong),
        .clear     (!en_i),
        .lock_o    (lock_o)
    );

endmodule

// File: tb/tb_cdma_despread_correlator.sv
// tb_cdma_despread_correlator: scoreboard bench for the despread correlator.
module tb_cdma_despread_correlator;

    logic clk_i = 1'b0, rst_i = 1'b1, en_i = 1'b0, sync_i = 1'b0, chip_en_i = 1'b0, chip_i = 1'b0;
    logic bit_o, bit_valid_o, strong_o, lock_o;
    logic [4:0] metric_o;

    typedef struct {int b; int m; int s; int l;} exp_t;
    exp_t q[$];
    int n_chk = 0, n_fail = 0;
    int scnt = 0, mcnt = 0, locked = 0;

    cdma_despread_correlator dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .sync_i(sync_i),
        .chip_en_i(chip_en_i), .chip_i(chip_i), .bit_o(bit_o),
        .bit_valid_o(bit_valid_o), .metric_o(metric_o),
        .strong_o(strong_o), .lock_o(lock_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: 31-chip symbols, strong at >=26 or <=5, lock 4 / miss 2.
    task automatic expect_sym(input int m);
        exp_t e;
        int s;
        s = (m >= 26 || m <= 5) ? 1 : 0;
        if (!locked) begin
            if (s) begin
                scnt++;
                if (scnt == 4) begin locked = 1; scnt = 0; mcnt = 0; end
            end else scnt = 0;
        end else begin
            if (!s) begin
                mcnt++;
                if (mcnt == 2) begin locked = 0; scnt = 0; mcnt = 0; end
            end else mcnt = 0;
        end
        e.b = (m > 15) ? 1 : 0; e.m = m; e.s = s; e.l = locked;
        q.push_back(e);
    endtask

    // Drives n chips (first `ones` are 1) spaced by `gap` idle cycles;
    // pre is the count of ones already accumulated in this symbol.
    task automatic send(input int n, input int ones, input int gap, input int pre,
                        input bit push, input bit sync_last);
        for (int i = 0; i < n; i++) begin
            chip_en_i = 1'b1;
            chip_i    = (i < ones);
            sync_i    = sync_last && i == n - 1;
            if (push && i == n - 1) expect_sym(pre + ones);
            tick();
            chip_en_i = 1'b0;
            sync_i    = 1'b0;
            if (push && i == n - 1) begin
                @(negedge clk_i);
                check("latency", bit_valid_o, 1);
            end
            repeat (gap) tick();
        end
    endtask

    task automatic do_sync();
        sync_i = 1'b1;
        tick();
        sync_i = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (bit_valid_o) begin
            if (q.size() == 0) check("spurious_valid", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                check("bit", bit_o, e.b);
                check("metric", metric_o, e.m);
                check("strong", strong_o, e.s);
                check("lock", lock_o, e.l);
            end
        end
    end

    initial begin
        repeat (3) tick();
        check("rst_bit", bit_o, 0);
        check("rst_valid", bit_valid_o, 0);
        check("rst_metric", metric_o, 0);
        check("rst_strong", strong_o, 0);
        check("rst_lock", lock_o, 0);
        rst_i = 1'b0;
        en_i  = 1'b1;
        tick();
        check("no_valid_after_rst", bit_valid_o, 0);
        do_sync();
        send(31, 31, 0, 0, 1, 0);
        send(31, 16, 0, 0, 1, 0);
        send(31, 15, 0, 0, 1, 0);
        send(31, 5, 0, 0, 1, 0);
        send(31, 31, 0, 0, 1, 0);
        send(31, 0, 0, 0, 1, 0);
        send(31, 28, 0, 0, 1, 0);
        send(31, 16, 0, 0, 1, 0);
        send(31, 31, 0, 0, 1, 0);
        send(31, 16, 0, 0, 1, 0);
        send(31, 15, 0, 0, 1, 0);
        // partial symbol discarded by a bare sync
        send(10, 10, 0, 0, 0, 0);
        do_sync();
        send(31, 20, 0, 0, 1, 0);
        // sync with a chip: that chip is chip 0
        send(7, 7, 0, 0, 0, 0);
        sync_i = 1'b1; chip_en_i = 1'b1; chip_i = 1'b1;
        tick();
        sync_i = 1'b0; chip_en_i = 1'b0;
        send(30, 12, 0, 1, 1, 0);
        // sync on the symbol-end chip: emits, then restarts cleanly
        send(31, 26, 0, 0, 1, 1);
        send(31, 3, 0, 0, 1, 0);
        // sparse strobes
        send(31, 31, 2, 0, 1, 0);
        send(31, 16, 2, 0, 1, 0);
        send(31, 30, 2, 0, 1, 0);
        // reach lock, then async reset mid-symbol
        repeat (4) send(31, 31, 0, 0, 1, 0);
        check("locked_before_rst", lock_o, 1);
        send(10, 10, 0, 0, 0, 0);
        #2 rst_i = 1'b1;
        #1;
        check("async_rst_lock", lock_o, 0);
        check("async_rst_metric", metric_o, 0);
        check("async_rst_bit", bit_o, 0);
        check("async_rst_strong", strong_o, 0);
        rst_i = 1'b0;
        scnt = 0; mcnt = 0; locked = 0;
        tick();
        send(31, 31, 0, 0, 0, 0);
        do_sync();
        send(31, 31, 0, 0, 1, 0);
        repeat (3) send(31, 0, 0, 0, 1, 0);
        check("locked_before_en", lock_o, 1);
        en_i = 1'b0;
        tick();
        @(negedge clk_i);
        check("en_low_lock", lock_o, 0);
        check("en_low_metric_hold", metric_o, 0);
        scnt = 0; mcnt = 0; locked = 0;
        en_i = 1'b1;
        send(31, 31, 0, 0, 0, 0);
        do_sync();
        send(31, 29, 1, 0, 1, 0);
        repeat (3) tick();
        check("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/cdma_despread_correlator.md
Name: cdma_despread_correlator

Overview:
- Downstream stage of the Gold-code spreader/despreader; it consumes the despread chip stream (receptor_o of the spreader, i.e. receptor_i XOR gold code).
- Integrates chips over one code period (CHIPS_PER_BIT chips, 31 for the 5-bit LFSR pair) and takes a majority decision to recover each data bit.
- Grades decision confidence and runs a lock detector that drives a status LED/flag.

Parameters:
- CHIPS_PER_BIT, 31, chips per data bit (one Gold period); must be ≥3 and odd.
- STRONG_THR, 26, minimum agreeing chips for a symbol to count as "strong".
- LOCK_CNT, 4, consecutive strong symbols needed to assert lock.
- MISS_CNT, 2, consecutive weak symbols that drop lock.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- en_i  in  1  block enable; low forces IDLE.
- sync_i  in  1  symbol-boundary pulse, aligned with spreader LFSR reload.
- chip_en_i  in  1  chip strobe; chip_i is sampled only when high.
- chip_i  in  1  despread chip.
- bit_o  out  1  recovered data bit.
- bit_valid_o  out  1  one-cycle pulse, bit_o/metric_o valid.
- metric_o  out  $clog2(CHIPS_PER_BIT+1)  count of '1' chips in the last symbol.
- strong_o  out  1  last symbol met STRONG_THR.
- lock_o  out  1  correlator locked.

Behaviour:
- Reset: asynchronous on rst_i high. All outputs 0, FSM in IDLE, accumulator, chip index and lock counters 0. Reset mid-symbol discards the partial symbol. No bit_valid_o pulse for at least one cycle after rst_i deasserts.
- Datapath FSM states: IDLE and ACCUM.
  - IDLE: chips are ignored.
  - IDLE→ACCUM on sync_i=1 while en_i=1.
  - en_i=0 in any state → IDLE next cycle. Accumulator, chip index, lock counters and lock_o are cleared. bit_o and metric_o hold.
- Accumulation in ACCUM:
  - Each chip_en_i=1 cycle: acc += chip_i and idx += 1.
  - idx runs 0..CHIPS_PER_BIT-1.
- Symbol end: a chip_en_i=1 cycle with idx==CHIPS_PER_BIT-1. Let sum = acc + chip_i. At the next clock edge:
  - metric_o <= sum.
  - bit_o <= (sum > CHIPS_PER_BIT/2), integer division.
  - strong_o <= (sum ≥ STRONG_THR) or (sum ≤ CHIPS_PER_BIT-STRONG_THR).
  - bit_valid_o <= 1 for exactly one cycle.
  - acc and idx <= 0; FSM stays in ACCUM.
  - Latency: last chip to bit_valid_o is 1 clock.
- sync_i while in ACCUM: the partial symbol is discarded (no valid pulse) and acc/idx restart.
  - If chip_en_i is also high, that chip becomes chip 0: acc=chip_i, idx=1.
  - If sync_i coincides with a symbol-end chip, the symbol completes and emits normally; accumulation then restarts with acc=0, idx=0.
- Lock FSM states: UNLOCKED and LOCKED, with a consecutive-strong counter and a consecutive-weak counter. Evaluated only on symbol end.
  - UNLOCKED: a strong symbol increments the strong counter; a weak symbol clears it. When the counter reaches LOCK_CNT: go to LOCKED, lock_o=1 in the same cycle as that symbol's bit_valid_o, clear counters.
  - LOCKED: a weak symbol increments the miss counter; a strong symbol clears it. When the miss counter reaches MISS_CNT: go to UNLOCKED, lock_o=0, clear counters.
  - sync_i does not affect lock state.
- Counters saturate and never wrap. The accumulator width holds CHIPS_PER_BIT without overflow.
- chip_en_i may be high every cycle (full rate) or sparse; behaviour is identical apart from timing.

Decomposition:
- Shared package cdma_pkg: CHIP_CNT_W function/constant, datapath state enum (IDLE, ACCUM), lock state enum (UNLOCKED, LOCKED), default GOLD_LEN=31.
- One natural sub-module: cdma_lock_detect. Inputs: sym_valid, sym_strong, clear. Output: lock_o. Holds the lock FSM and both counters.
- Accumulator and decision stay in the top module.

Test Plan:
- Reset, en_i=1, sync_i pulse, then 31 chips of 1 at full rate → one bit_valid_o pulse 1 cycle after the 31st chip: bit_o=1, metric_o=31, strong_o=1, lock_o=0.
- Symbols of 16 ones → bit_o=1, metric_o=16, strong_o=0. Symbols of 15 ones → bit_o=0, metric_o=15, strong_o=0. Symbols of 5 ones → bit_o=0, strong_o=1.
- Four consecutive strong symbols → lock_o rises with the 4th bit_valid_o. Then two weak symbols (metric 16) → lock_o falls with the 2nd. A strong symbol between two weak ones keeps lock.
- Sync handling:
  - sync_i after 10 chips → no valid pulse; the next 31 chips form one symbol.
  - sync_i coinciding with chip_en_i → that chip is counted as chip 0.
- chip_en_i high every 3rd cycle → same bits and metrics as the full-rate case, with valid 1 clock after the last strobed chip.
- rst_i asserted mid-symbol while locked → all outputs 0 immediately (async). Chips before a new sync_i are ignored. en_i=0 clears lock_o and returns to IDLE.
